// File: rtl/wb_merge_unit.sv
// rtl/wb_merge_unit.sv - merges four ex-stage result ports onto two scoreboard writeback ports
// Per-source FIFOs with round-robin arbitration; define WB_MERGE_BYPASS_EN for 0-cycle bypass of empty sources.
module wb_merge_unit #(
  parameter int DEPTH         = 4,
  parameter int AF_MARGIN     = 1,
  parameter int TRANS_ID_BITS = 3,
  parameter int EX_W          = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [3:0]                    src_valid_i,
  input  logic [3:0][TRANS_ID_BITS-1:0] src_trans_id_i,
  input  logic [3:0][63:0]              src_result_i,
  input  logic [3:0][EX_W-1:0]          src_ex_i,
  output logic [1:0]                    wb_valid_o,
  output logic [1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [1:0][63:0]              wb_result_o,
  output logic [1:0][EX_W-1:0]          wb_ex_o,
  output logic [3:0]                    src_almost_full_o,
  output logic                          overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TRANS_ID_BITS-1:0] r_id_mem  [4][DEPTH];
  logic [63:0]              r_res_mem [4][DEPTH];
  logic [EX_W-1:0]          r_ex_mem  [4][DEPTH];
  logic [PTR_W-1:0]         r_rd_ptr  [4];
  logic [PTR_W-1:0]         r_wr_ptr  [4];
  logic [CNT_W-1:0]         r_cnt     [4];
  logic [1:0]               r_rr;
  logic [3:0]               r_af;
  logic                     r_overflow;

  logic [3:0]               w_nonempty;
  logic [3:0]               w_cand;
  logic [3:0]               w_grant;
  logic [3:0]               w_byp_grant;
  logic [3:0]               w_pop;
  logic [3:0]               w_push_req;
  logic [3:0]               w_push;
  logic [3:0]               w_drop;
  logic [CNT_W-1:0]         w_cnt_next [4];
  logic [TRANS_ID_BITS-1:0] w_head_id  [4];
  logic [63:0]              w_head_res [4];
  logic [EX_W-1:0]          w_head_ex  [4];
  logic                     w_take0;
  logic                     w_take1;
  logic [1:0]               w_sel0;
  logic [1:0]               w_sel1;
  logic [1:0]               w_rr_next;

  // Heads and candidates; a bypassed empty source presents its input directly.
  always_comb begin
    for (int s = 0; s < 4; s++) begin
      w_nonempty[s] = (r_cnt[s] != '0);
`ifdef WB_MERGE_BYPASS_EN
      w_cand[s] = w_nonempty[s] | src_valid_i[s];
      if (!w_nonempty[s]) begin
        w_head_id[s]  = src_trans_id_i[s];
        w_head_res[s] = src_result_i[s];
        w_head_ex[s]  = src_ex_i[s];
      end else begin
        w_head_id[s]  = r_id_mem[s][r_rd_ptr[s]];
        w_head_res[s] = r_res_mem[s][r_rd_ptr[s]];
        w_head_ex[s]  = r_ex_mem[s][r_rd_ptr[s]];
      end
`else
      w_cand[s]     = w_nonempty[s];
      w_head_id[s]  = r_id_mem[s][r_rd_ptr[s]];
      w_head_res[s] = r_res_mem[s][r_rd_ptr[s]];
      w_head_ex[s]  = r_ex_mem[s][r_rd_ptr[s]];
`endif
    end
  end

  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    w_take0   = 1'b0;
    w_take1   = 1'b0;
    w_sel0    = '0;
    w_sel1    = '0;
    w_grant   = '0;
    w_rr_next = r_rr;
    for (int k = 0; k < 4; k++) begin
      idx = r_rr + 2'(k);
      if (w_cand[idx] && !flush_i) begin
        if (!w_take0) begin
          w_take0      = 1'b1;
          w_sel0       = idx;
          w_grant[idx] = 1'b1;
          w_rr_next    = idx + 2'd1;
        end else if (!w_take1) begin
          w_take1      = 1'b1;
          w_sel1       = idx;
          w_grant[idx] = 1'b1;
          w_rr_next    = idx + 2'd1;
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 4; s++) begin
      w_byp_grant[s] = w_grant[s] & ~w_nonempty[s];
      w_pop[s]       = w_grant[s] & w_nonempty[s];
      w_push_req[s]  = src_valid_i[s] & ~w_byp_grant[s];
      // A full queue still accepts when its head leaves in the same cycle.
      w_push[s]      = w_push_req[s] & ((r_cnt[s] != CNT_W'(DEPTH)) | w_pop[s]);
      w_drop[s]      = w_push_req[s] & ~w_push[s];
      w_cnt_next[s]  = r_cnt[s] + CNT_W'(w_push[s]) - CNT_W'(w_pop[s]);
    end
  end

  always_comb begin
    wb_valid_o    = {w_take1, w_take0};
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_ex_o       = '0;
    if (w_take0) begin
      wb_trans_id_o[0] = w_head_id[w_sel0];
      wb_result_o[0]   = w_head_res[w_sel0];
      wb_ex_o[0]       = w_head_ex[w_sel0];
    end
    if (w_take1) begin
      wb_trans_id_o[1] = w_head_id[w_sel1];
      wb_result_o[1]   = w_head_res[w_sel1];
      wb_ex_o[1]       = w_head_ex[w_sel1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < 4; s++) begin
      if (!rst_i && !flush_i && w_push[s]) begin
        r_id_mem[s][r_wr_ptr[s]]  <= src_trans_id_i[s];
        r_res_mem[s][r_wr_ptr[s]] <= src_result_i[s];
        r_ex_mem[s][r_wr_ptr[s]]  <= src_ex_i[s];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < 4; s++) begin
        r_rd_ptr[s] <= '0;
        r_wr_ptr[s] <= '0;
        r_cnt[s]    <= '0;
      end
      r_rr       <= '0;
      r_af       <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        r_af[s] <= (r_cnt[s] >= CNT_W'(DEPTH - AF_MARGIN));
      end
      if (flush_i) begin
        for (int s = 0; s < 4; s++) begin
          r_rd_ptr[s] <= '0;
          r_wr_ptr[s] <= '0;
          r_cnt[s]    <= '0;
        end
        r_rr <= '0;
      end else begin
        for (int s = 0; s < 4; s++) begin
          if (w_push[s]) r_wr_ptr[s] <= r_wr_ptr[s] + PTR_W'(1);
          if (w_pop[s])  r_rd_ptr[s] <= r_rd_ptr[s] + PTR_W'(1);
          r_cnt[s] <= w_cnt_next[s];
        end
        r_rr <= w_rr_next;
        if (|w_drop) r_overflow <= 1'b1;
      end
    end
  end

  assign src_almost_full_o = r_af;
  assign overflow_o        = r_overflow;

endmodule

// File: tb/tb_wb_merge_unit.sv
// tb/tb_wb_merge_unit.sv - directed self-checking bench for wb_merge_unit
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_wb_merge_unit;

  localparam int TID = 5;
  localparam int EXW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [3:0]           src_valid;
  logic [3:0][TID-1:0]  src_id;
  logic [3:0][63:0]     src_res;
  logic [3:0][EXW-1:0]  src_ex;
  logic [1:0]           wb_valid;
  logic [1:0][TID-1:0]  wb_id;
  logic [1:0][63:0]     wb_res;
  logic [1:0][EXW-1:0]  wb_ex;
  logic [3:0]           af;
  logic                 ovf;

  int checks   = 0;
  int failures = 0;

  wb_merge_unit #(.DEPTH(4), .AF_MARGIN(1), .TRANS_ID_BITS(TID), .EX_W(EXW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .src_valid_i(src_valid), .src_trans_id_i(src_id), .src_result_i(src_res), .src_ex_i(src_ex),
    .wb_valid_o(wb_valid), .wb_trans_id_o(wb_id), .wb_result_o(wb_res), .wb_ex_o(wb_ex),
    .src_almost_full_o(af), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    flush = 1'b0; src_valid = '0; src_id = '0; src_res = '0; src_ex = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin failures++; $display("FAIL reset_wb_valid got=%0h exp=0", wb_valid); end
    checks++; if (wb_res !== '0) begin failures++; $display("FAIL reset_wb_result got=%0h exp=0", wb_res); end
    checks++; if (af !== 4'b0000) begin failures++; $display("FAIL reset_af got=%0h exp=0", af); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", ovf); end
  endtask

  task automatic test_single_load();
    do_reset();
    src_valid = 4'b0010; src_id[1] = 5'd5; src_res[1] = 64'hDEAD; src_ex[1] = 8'h3C;
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin failures++; $display("FAIL load_same_cycle got=%0h exp=0", wb_valid); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (wb_valid !== 2'b01) begin failures++; $display("FAIL load_valid got=%0h exp=1", wb_valid); end
    checks++; if (wb_id[0] !== 5'd5) begin failures++; $display("FAIL load_id got=%0h exp=5", wb_id[0]); end
    checks++; if (wb_res[0] !== 64'hDEAD) begin failures++; $display("FAIL load_result got=%0h exp=dead", wb_res[0]); end
    checks++; if (wb_ex[0] !== 8'h3C) begin failures++; $display("FAIL load_ex got=%0h exp=3c", wb_ex[0]); end
    checks++; if (wb_res[1] !== 64'h0) begin failures++; $display("FAIL load_port1_zero got=%0h exp=0", wb_res[1]); end
    tick();
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin failures++; $display("FAIL load_idle got=%0h exp=0", wb_valid); end
  endtask

  task automatic test_all_four();
    do_reset();
    src_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin src_id[s] = TID'(s + 1); src_res[s] = 64'(100 + s); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (wb_valid !== 2'b11) begin failures++; $display("FAIL rr1_valid got=%0h exp=3", wb_valid); end
    checks++; if ({wb_id[0], wb_id[1]} !== {5'd1, 5'd2}) begin failures++; $display("FAIL rr1_ids got=%0h,%0h exp=1,2", wb_id[0], wb_id[1]); end
    tick();
    @(negedge clk);
    checks++; if ({wb_id[0], wb_id[1]} !== {5'd3, 5'd4}) begin failures++; $display("FAIL rr2_ids got=%0h,%0h exp=3,4", wb_id[0], wb_id[1]); end
    checks++; if (wb_res[1] !== 64'd103) begin failures++; $display("FAIL rr2_result got=%0h exp=67", wb_res[1]); end
    tick();
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin failures++; $display("FAIL rr3_idle got=%0h exp=0", wb_valid); end
    // rr back at 0: FLU must win port 0 over FPU
    src_valid = 4'b1001; src_id[0] = 5'd6; src_id[3] = 5'd7;
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if ({wb_id[0], wb_id[1]} !== {5'd6, 5'd7}) begin failures++; $display("FAIL rr_end_zero got=%0h,%0h exp=6,7", wb_id[0], wb_id[1]); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      src_valid = 4'b0001; src_id[0] = TID'(i);
      tick();
    end
    clear_inputs();
    flush = 1'b1; src_valid = 4'b0010; src_id[1] = 5'd9;
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin failures++; $display("FAIL flush_cycle_valid got=%0h exp=0", wb_valid); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin failures++; $display("FAIL flush_after_valid got=%0h exp=0", wb_valid); end
    src_valid = 4'b1001; src_id[0] = 5'd6; src_id[3] = 5'd7;
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if ({wb_id[0], wb_id[1]} !== {5'd6, 5'd7}) begin failures++; $display("FAIL flush_rr_zero got=%0h,%0h exp=6,7", wb_id[0], wb_id[1]); end
    tick();
  endtask

  // All four sources valid for 8 cycles: queues fill, FPU/store overflow on the 8th.
  task automatic test_saturate();
    int beats;
    int fpu_n;
    int fpu_e [$];
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      src_valid = 4'b1111;
      for (int s = 0; s < 4; s++) begin src_id[s] = TID'(e); src_res[s] = 64'(s * 16 + e); end
      if (e == 7) begin
        @(negedge clk);
        checks++; if ({wb_res[0], wb_res[1]} !== {64'd35, 64'd51}) begin failures++; $display("FAIL sat_c7_heads got=%0d,%0d exp=35,51", wb_res[0], wb_res[1]); end
      end
      tick();
      if (e == 5) begin
        checks++; if (af !== 4'b1100) begin failures++; $display("FAIL sat_af_e5 got=%0h exp=c", af); end
      end
      if (e == 6) begin
        checks++; if (af !== 4'b1111) begin failures++; $display("FAIL sat_af_e6 got=%0h exp=f", af); end
      end
      if (e == 7) begin
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL full_enq_deq_ovf got=%0h exp=0", ovf); end
      end
      if (e == 8) begin
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL overflow_set got=%0h exp=1", ovf); end
      end
    end
    clear_inputs();
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p]) begin
          beats++;
          if (wb_res[p][7:4] == 4'd3) fpu_e.push_back(int'(wb_res[p][3:0]));
        end
      end
      tick();
    end
    checks++; if (beats != 16) begin failures++; $display("FAIL drain_beats got=%0d exp=16", beats); end
    fpu_n = fpu_e.size();
    checks++; if (fpu_n != 4) begin failures++; $display("FAIL drain_fpu_count got=%0d exp=4", fpu_n); end
    for (int i = 0; i < 4 && i < fpu_n; i++) begin
      checks++; if (fpu_e[i] != i + 4) begin failures++; $display("FAIL drain_fpu_order[%0d] got=%0d exp=%0d", i, fpu_e[i], i + 4); end
    end
    checks++; if (af !== 4'b0000) begin failures++; $display("FAIL drain_af got=%0h exp=0", af); end
    flush = 1'b1;
    tick(); flush = 1'b0;
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL flush_keeps_ovf got=%0h exp=1", ovf); end
  endtask

  task automatic test_reset_mid();
    src_valid = 4'b1111;
    tick(); clear_inputs();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin failures++; $display("FAIL midreset_valid got=%0h exp=0", wb_valid); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL midreset_ovf got=%0h exp=0", ovf); end
    tick();
  endtask

  task automatic test_bypass();
    do_reset();
    src_valid = 4'b0001; src_id[0] = 5'd7;
    @(negedge clk);
    checks++; if (wb_valid !== 2'b01) begin failures++; $display("FAIL byp_valid got=%0h exp=1", wb_valid); end
    checks++; if (wb_id[0] !== 5'd7) begin failures++; $display("FAIL byp_id got=%0h exp=7", wb_id[0]); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (wb_valid !== 2'b00) begin failures++; $display("FAIL byp_not_queued got=%0h exp=0", wb_valid); end
    do_reset();
    src_valid = 4'b0111; src_id[0] = 5'd1; src_id[1] = 5'd2; src_id[2] = 5'd3;
    @(negedge clk);
    checks++; if ({wb_id[0], wb_id[1]} !== {5'd1, 5'd2}) begin failures++; $display("FAIL byp_pair got=%0h,%0h exp=1,2", wb_id[0], wb_id[1]); end
    tick(); clear_inputs();
    @(negedge clk);
    checks++; if (wb_valid !== 2'b01 || wb_id[0] !== 5'd3) begin failures++; $display("FAIL byp_loser_queued got=%0h/%0h exp=1/3", wb_valid, wb_id[0]); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
`ifdef WB_MERGE_BYPASS_EN
    test_bypass();
`else
    test_single_load();
    test_all_four();
    test_flush();
    test_saturate();
    test_reset_mid();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
